// File: rtl/psion_pkg.sv
// Shared constants and types for the Psion frame-buffer arbiter.
package psion_pkg;

  localparam int FB_ADDR_W = 14;
  localparam int FB_DATA_W = 16;
  localparam int FB_WORDS  = 9600;

  // Arbiter state encoding; also the RAM command presented this cycle.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  // One buffered host write.
  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/psion_fb_wfifo.sv
// Synchronous host-write FIFO. Push is ignored when full and pop is
// ignored when empty, so a push and a pop at full can never collide.
module psion_fb_wfifo
  import psion_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  wr_entry_t              push_data_i,
  input  logic                   pop_i,
  output wr_entry_t              head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  wr_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage needs no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/psion_fb_arbiter.sv
// Frame-buffer RAM arbiter: display reads versus buffered host writes,
// with a starvation limit so queued writes eventually get through.
//
// state   | meaning
// --------+-------------------------------------------
// ST_IDLE | no RAM command this cycle (ram_we = 0)
// ST_RD   | read command on RAM outputs (rd_gnt = 1)
// ST_WR   | FIFO head write on RAM outputs (ram_we = 1)
module psion_fb_arbiter
  import psion_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rd_req,
  input  logic [FB_ADDR_W-1:0]        rd_addr,
  output logic                        rd_gnt,
  output logic                        rd_valid,
  output logic [FB_DATA_W-1:0]        rd_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [FB_ADDR_W-1:0]        wr_addr,
  input  logic [FB_DATA_W-1:0]        wr_data,
  output logic [FB_ADDR_W-1:0]        ram_addr,
  output logic [FB_DATA_W-1:0]        ram_wdata,
  output logic                        ram_we,
  input  logic [FB_DATA_W-1:0]        ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0] wr_pending
);

  localparam int               SC_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic [1:0]           state_q, state_d;
  logic [SC_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic [FB_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [FB_DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic                 rd_valid_q;
  logic                 do_rd, do_wr;

  wr_entry_t push_entry, head;
  logic      fifo_full, fifo_empty;

  assign push_entry = '{addr: wr_addr, data: wr_data};

  psion_fb_wfifo #(.DEPTH(FIFO_DEPTH)) u_wfifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (wr_valid),
    .push_data_i (push_entry),
    .pop_i       (do_wr),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (wr_pending)
  );

  // Pick this cycle's command; the head write also pops the FIFO right away.
  always_comb begin
    do_wr        = !fifo_empty && (!rd_req || (starve_cnt_q == STARVE_MAX));
    do_rd        = rd_req && !do_wr;
    state_d      = do_wr ? ST_WR : (do_rd ? ST_RD : ST_IDLE);
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    starve_cnt_d = starve_cnt_q;
    if (do_wr) begin
      ram_addr_d  = head.addr;
      ram_wdata_d = head.data;
    end else if (do_rd) begin
      ram_addr_d  = rd_addr;
    end
    // Reads only count as starving a write when one is actually waiting.
    if (do_wr || fifo_empty) begin
      starve_cnt_d = '0;
    end else if (do_rd && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
  end

  // Register the command; reset also kills any read granted in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rd_valid_q   <= (state_q == ST_RD);
    end
  end

  assign rd_gnt    = (state_q == ST_RD);
  assign ram_we    = (state_q == ST_WR);
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rd_valid  = rd_valid_q;
  // RAM data arrives the cycle after the command, so it is passed straight through.
  assign rd_data   = rd_valid_q ? ram_rdata : '0;
  assign wr_ready  = !fifo_full;

endmodule

// File: tb/tb_psion_fb_arbiter.sv
// Directed bench for psion_fb_arbiter with a synchronous-read RAM model.
module tb_psion_fb_arbiter;
  import psion_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [13:0] rd_addr = '0;
  logic        rd_gnt, rd_valid;
  logic [15:0] rd_data;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [13:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [13:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata = '0;
  logic [2:0]  wr_pending;

  int n_vec = 0;
  int n_err = 0;

  psion_fb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .wr_pending(wr_pending)
  );

  always #5 clk = ~clk;

  // RAM contents: 0x0010 holds 0x1234, every other word is addr ^ 0xC3C3.
  function automatic logic [15:0] rom_word(input logic [13:0] a);
    return (a == 14'h0010) ? 16'h1234 : ({2'b00, a} ^ 16'hC3C3);
  endfunction

  always @(posedge clk) ram_rdata <= rom_word(ram_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rd_req = 1'b1;
    rd_addr = 14'h0033;
    tick; tick;
    n_vec++;
    if ({rd_gnt, rd_valid, ram_we, wr_ready} !== 4'b0001) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0001", {rd_gnt, rd_valid, ram_we, wr_ready});
    end
    n_vec++;
    if ({ram_addr, ram_wdata, rd_data, wr_pending} !== 49'd0) begin
      n_err++; $display("FAIL reset_values: addr %h wdata %h rdata %h pend %0d expected all 0", ram_addr, ram_wdata, rd_data, wr_pending);
    end
    reset = 1'b0;
    #2;
    n_vec++;
    if (rd_gnt !== 1'b0) begin
      n_err++; $display("FAIL first_cmd_early: rd_gnt %b expected 0", rd_gnt);
    end
    tick;
    rd_req = 1'b0;
    n_vec++;
    if (rd_gnt !== 1'b1 || ram_addr !== 14'h0033) begin
      n_err++; $display("FAIL first_cmd: rd_gnt %b addr %h expected 1 0033", rd_gnt, ram_addr);
    end
    tick; tick;
  endtask

  task automatic test_write_only(input logic [13:0] a, input logic [15:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick;
    wr_valid = 1'b0;
    n_vec++;
    if (wr_pending !== 3'd1 || ram_we !== 1'b0) begin
      n_err++; $display("FAIL wr_queued: pend %0d we %b expected 1 0", wr_pending, ram_we);
    end
    tick;
    n_vec++;
    if (ram_we !== 1'b1 || ram_addr !== a || ram_wdata !== d || wr_pending !== 3'd0) begin
      n_err++; $display("FAIL wr_issue: we %b addr %h data %h pend %0d expected 1 %h %h 0", ram_we, ram_addr, ram_wdata, wr_pending, a, d);
    end
    tick;
    n_vec++;
    if (ram_we !== 1'b0 || ram_addr !== a || ram_wdata !== d) begin
      n_err++; $display("FAIL idle_hold: we %b addr %h data %h expected 0 %h %h", ram_we, ram_addr, ram_wdata, a, d);
    end
  endtask

  task automatic test_read_latency;
    rd_addr = 14'h0010; rd_req = 1'b1;
    tick;
    rd_req = 1'b0;
    n_vec++;
    if (rd_gnt !== 1'b1 || rd_valid !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 14'h0010) begin
      n_err++; $display("FAIL rd_gnt: gnt %b valid %b we %b addr %h expected 1 0 0 0010", rd_gnt, rd_valid, ram_we, ram_addr);
    end
    tick;
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h1234 || rd_gnt !== 1'b0) begin
      n_err++; $display("FAIL rd_valid: valid %b data %h gnt %b expected 1 1234 0", rd_valid, rd_data, rd_gnt);
    end
    tick;
    n_vec++;
    if (rd_valid !== 1'b0) begin
      n_err++; $display("FAIL rd_valid_pulse: valid %b expected 0", rd_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [13:0] addrs [3];
    logic [15:0] datas [3];
    addrs = '{14'h0020, 14'h0021, 14'h2580};
    datas = '{16'hC3E3, 16'hC3E2, 16'hE643};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin rd_req = 1'b1; rd_addr = addrs[i]; end
      else rd_req = 1'b0;
      tick;
      n_vec++;
      if (i < 3) begin
        if (rd_gnt !== 1'b1 || ram_addr !== addrs[i]) begin
          n_err++; $display("FAIL b2b_gnt[%0d]: gnt %b addr %h expected 1 %h", i, rd_gnt, ram_addr, addrs[i]);
        end
      end else if (rd_gnt !== 1'b0) begin
        n_err++; $display("FAIL b2b_end: gnt %b expected 0", rd_gnt);
      end
      if (i > 0) begin
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== datas[i-1]) begin
          n_err++; $display("FAIL b2b_data[%0d]: valid %b data %h expected 1 %h", i-1, rd_valid, rd_data, datas[i-1]);
        end
      end
    end
    tick;
  endtask

  task automatic test_starvation;
    int  cnt = 0;
    bit  seen = 0;
    rd_req = 1'b1; rd_addr = 14'h0100;
    tick;
    wr_valid = 1'b1; wr_addr = 14'h0200; wr_data = 16'hBEEF;
    tick;
    wr_valid = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick;
      if (ram_we) seen = 1;
      else if (rd_gnt) cnt++;
    end
    n_vec++;
    if (!seen || cnt != 8) begin
      n_err++; $display("FAIL starve_count: write seen %0d after %0d reads expected 1 after 8", seen, cnt);
    end
    n_vec++;
    if (ram_addr !== 14'h0200 || ram_wdata !== 16'hBEEF || rd_gnt !== 1'b0) begin
      n_err++; $display("FAIL starve_write: addr %h data %h gnt %b expected 0200 beef 0", ram_addr, ram_wdata, rd_gnt);
    end
    tick;
    n_vec++;
    if (rd_gnt !== 1'b1 || wr_pending !== 3'd0) begin
      n_err++; $display("FAIL starve_resume: gnt %b pend %0d expected 1 0", rd_gnt, wr_pending);
    end
    rd_req = 1'b0;
    tick; tick;
  endtask

  task automatic test_full_fifo;
    rd_req = 1'b1; rd_addr = 14'h0300;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 14'h0400 + 14'(i); wr_data = 16'hD000 + 16'(i);
      tick;
    end
    n_vec++;
    if (wr_ready !== 1'b0 || wr_pending !== 3'd4) begin
      n_err++; $display("FAIL full: ready %b pend %0d expected 0 4", wr_ready, wr_pending);
    end
    wr_addr = 14'h04FF; wr_data = 16'hDEAD;
    tick;
    wr_valid = 1'b0; rd_req = 1'b0;
    n_vec++;
    if (wr_pending !== 3'd4 || rd_gnt !== 1'b1 || ram_we !== 1'b0) begin
      n_err++; $display("FAIL fifth_push: pend %0d gnt %b we %b expected 4 1 0", wr_pending, rd_gnt, ram_we);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      n_vec++;
      if (ram_we !== 1'b1 || ram_addr !== 14'h0400 + 14'(i) || ram_wdata !== 16'hD000 + 16'(i) || wr_ready !== 1'b1) begin
        n_err++; $display("FAIL drain[%0d]: we %b addr %h data %h ready %b expected 1 %h %h 1", i, ram_we, ram_addr, ram_wdata, wr_ready, 14'h0400 + 14'(i), 16'hD000 + 16'(i));
      end
    end
    tick;
    n_vec++;
    if (ram_we !== 1'b0 || wr_pending !== 3'd0) begin
      n_err++; $display("FAIL drain_end: we %b pend %0d expected 0 0", ram_we, wr_pending);
    end
  endtask

  task automatic test_push_pop;
    rd_req = 1'b1; rd_addr = 14'h0500;
    wr_valid = 1'b1; wr_addr = 14'h0600; wr_data = 16'h0A0A;
    tick;
    wr_addr = 14'h0601; wr_data = 16'h0B0B;
    tick;
    n_vec++;
    if (wr_pending !== 3'd2) begin
      n_err++; $display("FAIL pp_fill: pend %0d expected 2", wr_pending);
    end
    rd_req = 1'b0;
    wr_addr = 14'h0602; wr_data = 16'h0C0C;
    tick;
    wr_valid = 1'b0;
    n_vec++;
    if (wr_pending !== 3'd2 || ram_we !== 1'b1 || ram_addr !== 14'h0600 || ram_wdata !== 16'h0A0A) begin
      n_err++; $display("FAIL pp_same: pend %0d we %b addr %h data %h expected 2 1 0600 0a0a", wr_pending, ram_we, ram_addr, ram_wdata);
    end
    tick;
    n_vec++;
    if (ram_we !== 1'b1 || ram_addr !== 14'h0601 || ram_wdata !== 16'h0B0B) begin
      n_err++; $display("FAIL pp_second: we %b addr %h data %h expected 1 0601 0b0b", ram_we, ram_addr, ram_wdata);
    end
    tick;
    n_vec++;
    if (ram_we !== 1'b1 || ram_addr !== 14'h0602 || ram_wdata !== 16'h0C0C || wr_pending !== 3'd0) begin
      n_err++; $display("FAIL pp_third: we %b addr %h data %h pend %0d expected 1 0602 0c0c 0", ram_we, ram_addr, ram_wdata, wr_pending);
    end
    tick;
  endtask

  task automatic test_reset_midop;
    bit bad = 0;
    rd_req = 1'b1; rd_addr = 14'h0700;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 14'h0800 + 14'(i); wr_data = 16'h5500 + 16'(i);
      tick;
    end
    wr_valid = 1'b0;
    n_vec++;
    if (wr_pending !== 3'd3 || rd_gnt !== 1'b1) begin
      n_err++; $display("FAIL midop_setup: pend %0d gnt %b expected 3 1", wr_pending, rd_gnt);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({rd_gnt, rd_valid, ram_we, wr_ready} !== 4'b0001 || wr_pending !== 3'd0 || ram_addr !== 14'd0) begin
      n_err++; $display("FAIL midop_reset: flags %b pend %0d addr %h expected 0001 0 0000", {rd_gnt, rd_valid, ram_we, wr_ready}, wr_pending, ram_addr);
    end
    rd_req = 1'b0;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (ram_we !== 1'b0 || rd_valid !== 1'b0 || rd_gnt !== 1'b0 || wr_pending !== 3'd0 || wr_ready !== 1'b1) bad = 1;
    end
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL midop_after: activity after reset, we %b valid %b pend %0d", ram_we, rd_valid, wr_pending);
    end
  endtask

  initial begin
    test_reset;
    test_write_only(14'h0005, 16'hA5A5);
    test_write_only(14'h3FFF, 16'h0F0F);
    test_read_latency;
    test_back_to_back;
    test_starvation;
    test_full_fifo;
    test_push_pop;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/psion_fb_arbiter.md
PSION_FB_ARBITER -- requirements
Module: psion_fb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, 4, depth of the host write buffer; SHALL be a power of two, minimum 2.
REQ-002 Parameter STARVE_LIMIT, 8, maximum consecutive read grants while a write is pending.
REQ-003 Port clk  in  1  single system clock (24 MHz); the block SHALL have one clock.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port rd_req  in  1  display scan requests a frame-buffer word; held high until rd_gnt.
REQ-006 Port rd_addr  in  14  word address, 0..9599 (160x240 nibbles, 4 nibbles/word).
REQ-007 Port rd_gnt  out  1  one-cycle pulse: read command issued to RAM.
REQ-008 Port rd_valid  out  1  one-cycle pulse: rd_data valid.
REQ-009 Port rd_data  out  16  read word, bits [3:0] = leftmost pixel nibble.
REQ-010 Port wr_valid  in  1  host write offered.
REQ-011 Port wr_ready  out  1  write FIFO not full.
REQ-012 Port wr_addr  in  14  host word address.
REQ-013 Port wr_data  in  16  host word.
REQ-014 Port ram_addr  out  14  registered RAM address.
REQ-015 Port ram_wdata  out  16  registered RAM write data.
REQ-016 Port ram_we  out  1  registered RAM write enable.
REQ-017 Port ram_rdata  in  16  RAM read data, valid one cycle after the command cycle.
REQ-018 Port wr_pending  out  2+  current FIFO occupancy, log2(FIFO_DEPTH)+1 bits.

Function
REQ-019 A write SHALL be accepted into the FIFO on any rising clk edge where wr_valid and wr_ready are both high.
REQ-020 wr_ready SHALL be low exactly when occupancy equals FIFO_DEPTH; a simultaneous push and pop at full SHALL be disallowed by wr_ready and never corrupt data.
REQ-021 Each cycle the arbiter SHALL issue at most one RAM command, registered into ram_addr/ram_wdata/ram_we.
REQ-022 Priority: read wins when rd_req is high, unless starve_cnt equals STARVE_LIMIT and the FIFO is non-empty, in which case the FIFO head write wins.
REQ-023 starve_cnt SHALL increment on each read grant while the FIFO is non-empty, clear on any write grant or when the FIFO is empty, and saturate at STARVE_LIMIT.
REQ-024 With no rd_req and a non-empty FIFO, the head write SHALL be issued and popped that cycle.
REQ-025 rd_gnt SHALL pulse in the cycle the read command is presented on the RAM outputs; rd_valid SHALL pulse exactly one cycle later, with rd_data = ram_rdata.
REQ-026 rd_req still high in the cycle after rd_gnt SHALL be treated as a new request (back-to-back reads, one per cycle).
REQ-027 Idle cycles SHALL drive ram_we=0; ram_addr and ram_wdata hold their last values.
REQ-028 Writes SHALL reach RAM in acceptance order; there is no read-after-write forwarding, so a read may return pre-write data (tearing is acceptable).
REQ-029 Addresses >= 9600 SHALL be passed through unchanged; the arbiter performs no range checking.
REQ-030 States: IDLE (no command), RD (read issued), WR (write issued); the next state is chosen every cycle from REQ-022/024, and every state can reach any state.

Reset
REQ-031 While reset is high: rd_gnt=0, rd_valid=0, rd_data=0, ram_we=0, ram_addr=0, ram_wdata=0, wr_pending=0, wr_ready=1, starve_cnt=0, state=IDLE.
REQ-032 Reset asserted mid-operation SHALL discard all FIFO contents and any in-flight read; rd_valid SHALL NOT pulse for a read granted in the cycle reset rises.
REQ-033 The first command SHALL be issued no earlier than the first rising edge after reset deasserts.

Structure
REQ-034 Package psion_pkg SHALL hold FB_ADDR_W=14, FB_DATA_W=16, FB_WORDS=9600, and the state encoding.
REQ-035 The write buffer SHALL be one sub-module, psion_fb_wfifo (synchronous FIFO with push/pop/full/empty/count); arbitration stays in the top module.

Verification
REQ-036 Write only: push addr 0x0005 data 0xA5A5 -> ram_we=1 with ram_addr=0x0005 and ram_wdata=0xA5A5 one cycle later; wr_pending returns to 0.
REQ-037 Read latency: rd_req with rd_addr=0x0010 and ram_rdata model = 0x1234 -> rd_gnt at cycle N, rd_valid at N+1 with rd_data=0x1234.
REQ-038 Starvation: rd_req held high continuously with one write queued -> exactly 8 read grants, then 1 write grant, then reads resume.
REQ-039 Full FIFO: 4 pushes while rd_req is held high -> wr_ready=0 and wr_pending=4; a fifth wr_valid is not accepted; all 4 writes drain in order.
REQ-040 Simultaneous push and pop at occupancy 2 -> occupancy stays 2 and data order is preserved.
REQ-041 Reset pulse with 3 queued writes and a read just granted -> no rd_valid, no ram_we after reset, wr_pending=0, wr_ready=1.
